// File: rtl/pixel_scan_feeder_pkg.sv
// Shared constants and state encoding for the pixel scan feeder.
//   Default image geometry (320x240, RGB444, 17-bit source address) and the
//   coordinate widths used on the i_p/j_p outputs.
package pixel_scan_feeder_pkg;

  localparam int unsigned IMG_W_DEF  = 320;
  localparam int unsigned IMG_H_DEF  = 240;
  localparam int unsigned PIX_W_DEF  = 12;
  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned I_W        = 9;
  localparam int unsigned J_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry valid/ready buffer.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous empty (has priority over push)
//   push/wdata : write side; caller guarantees no push into a full buffer unless a pop
//                happens in the same cycle
//   valid/ready/rdata : read side, head entry held stable until popped
//   count      : current occupancy 0..2
module pix_fifo2 #(
  parameter int unsigned W = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   count_q;
  logic         pop, push_ok;

  assign valid   = (count_q != 2'd0);
  assign pop     = valid & ready;
  assign push_ok = push & ((count_q != 2'd2) | pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      count_q <= count_q + 2'(push_ok) - 2'(pop);
    end
  end

endmodule

// File: rtl/pixel_scan_feeder.sv
// Raster-scans the source image RAM and streams one pixel per beat with its (column, row)
// coordinates under valid/ready. A 2-entry buffer absorbs the 1-cycle RAM read latency.
//   start/abort          : frame start pulse; synchronous flush to idle (abort wins)
//   rd_en/rd_addr/rd_data: synchronous source RAM port, data one cycle after rd_en
//   pixel, i_p, j_p, pixel_last, pixel_valid, pixel_ready : output stream
//   Tx                   : pixel_valid & pixel_ready
//   busy, done, frame_count : status; frame_count counts completed frames only
module pixel_scan_feeder
  import pixel_scan_feeder_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pixel,
  output logic [I_W-1:0]    i_p,
  output logic [J_W-1:0]    j_p,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_last,
  output logic              Tx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count
);

  localparam int unsigned TagW = I_W + J_W + 1;
  localparam int unsigned EntW = PIX_W + TagW;

  state_e            state_q, state_d;
  logic [I_W-1:0]    i_q, i_d;
  logic [J_W-1:0]    j_q, j_d;
  logic              inflight_q;
  logic [TagW-1:0]   tag_q;
  logic [15:0]       frame_count_q;
  logic [1:0]        fifo_count;
  logic [EntW-1:0]   fifo_rdata;
  logic              scan_last;
  logic [2:0]        occ;
  logic              credit_ok;

  assign scan_last = (i_q == I_W'(IMG_W - 1)) && (j_q == J_W'(IMG_H - 1));

  // A beat leaving this cycle frees a slot, which keeps one read issued per clock.
  assign occ       = 3'(fifo_count) + 3'(inflight_q);
  assign credit_ok = occ < (3'd2 + 3'(Tx));
  assign rd_en     = (state_q == ST_RUN) & ~abort & pixel_ready & credit_ok;
  assign rd_addr   = ADDR_W'(j_q) * ADDR_W'(IMG_W) + ADDR_W'(i_q);

  assign Tx          = pixel_valid & pixel_ready;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE) & ~abort;
  assign frame_count = frame_count_q;
  assign {pixel, i_p, j_p, pixel_last} = fifo_rdata;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          i_d     = '0;
          j_d     = '0;
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          if (i_q == I_W'(IMG_W - 1)) begin
            i_d = '0;
            j_d = j_q + 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
          if (scan_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last beat leaving means nothing remains buffered or in flight.
        if ((Tx & pixel_last) | ((fifo_count == 2'd0) & ~inflight_q)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      inflight_q    <= 1'b0;
      tag_q         <= '0;
      frame_count_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      inflight_q <= rd_en;
      if (rd_en) tag_q <= {i_q, j_q, scan_last};
      if (done) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // Abort flushes the buffer and blocks the write of any read returning that cycle.
  pix_fifo2 #(
    .W (EntW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (inflight_q),
    .wdata ({rd_data, tag_q}),
    .valid (pixel_valid),
    .ready (pixel_ready),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

endmodule
